bus_transfer_sequencer: RTL
===========================

Name: bus_transfer_sequencer

Overview:
- Control-side stage directly upstream of the 32-to-5 bus-source encoder.
- Accepts a register-transfer command (source code, destination code) over a valid/ready handshake.
- Drives exactly one one-hot source "out" strobe, which the encoder converts back to the bus select code, for a settle window. Then pulses one destination load strobe and signals completion.
- Register codes are the datapath bus codes: 1=R0 … 16=R15, 17=HI, 18=LO, 19=ZHI, 20=ZLO, 21=PC, 22=MDR, 23=Inport, 24=C. Code 0 means no source.

Parameters:
- NUM_SRC, 24, number of bus sources/destinations; bit i of a strobe vector corresponds to code i+1.
- CODE_W, 5, width of source/destination codes.
- SETTLE_CYCLES, 1, cycles src_out is held before the destination load; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_src  in  CODE_W  source bus code.
- cmd_dst  in  CODE_W  destination bus code.
- src_out  out  NUM_SRC  one-hot source drive strobes, fed to the encoder inputs r0Signal..CSignal.
- dst_in  out  NUM_SRC  one-hot destination load strobes.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- cmd_error  out  1  sticky flag: last accepted command was invalid.

Behaviour:
- Reset is asynchronous and active-low. While clear=0, all of the following hold immediately, independent of clock:
  - state=IDLE.
  - src_out=0, dst_in=0, done=0, cmd_error=0, busy=0.
  - cmd_ready=0.
  - Internal counter=0.
  - cmd_ready rises in the first cycle after clear deasserts.
- FSM states are IDLE, DRIVE, LATCH. All outputs are registered except cmd_ready, which equals (state==IDLE && clear).
- Accept happens at a rising edge when cmd_valid && cmd_ready. Command fields are captured into internal registers; inputs are don't-care afterwards.
- Validity check at accept:
  - Valid requires 1 ≤ cmd_src ≤ NUM_SRC and 1 ≤ cmd_dst ≤ NUM_SRC.
  - cmd_src == cmd_dst is legal (self-reload).
- Invalid accept:
  - State stays IDLE; no strobes and no done.
  - cmd_error is set at that edge and stays set until the next valid accept clears it.
- Valid accept at edge k:
  - After edge k: state=DRIVE, busy=1, src_out=1<<(cmd_src-1), counter=SETTLE_CYCLES-1, cmd_error cleared.
  - In DRIVE: each edge decrements the counter. The edge where the counter equals 0 moves to LATCH; this is edge k+SETTLE_CYCLES.
  - In LATCH: src_out is held and dst_in=1<<(cmd_dst-1) for exactly one cycle.
  - Next edge (k+SETTLE_CYCLES+1): state=IDLE, src_out=0, dst_in=0, busy=0, done=1 for one cycle.
- Latency from accept to done is SETTLE_CYCLES+1 edges. Throughput is one transfer per SETTLE_CYCLES+2 cycles; the earliest next accept is at edge k+SETTLE_CYCLES+2.
- Strobe invariants: src_out and dst_in are each zero or one-hot. src_out is never zero while dst_in is nonzero.
- cmd_valid held high with cmd_ready low is ignored. No command queuing.
- Reset asserted mid-transfer aborts immediately: strobes drop, no done, and the transfer is not resumed.

Optional Feature:
- Macro: BUS_XFER_COUNT_EN.
- Defined:
  - Adds output xfer_count [15:0], reset to 0.
  - Increments by 1 on each done pulse and saturates at 16'hFFFF.
  - Invalid commands are not counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package bus_xfer_pkg holds:
  - State enum (IDLE, DRIVE, LATCH).
  - Code constants CODE_NONE=0, CODE_R0=1 … CODE_R15=16, CODE_HI=17, CODE_LO=18, CODE_ZHI=19, CODE_ZLO=20, CODE_PC=21, CODE_MDR=22, CODE_INPORT=23, CODE_C=24.
  - NUM_SRC and CODE_W defaults.
- Sub-module bus_code_decoder:
  - Combinational CODE_W → NUM_SRC one-hot decoder with a valid output (code in 1..NUM_SRC).
  - Instantiated twice, for source and destination, at the accept point.

Test Plan:
- Reset then single transfer (SETTLE=1). src=22 (MDR), dst=21 (PC) accepted at edge 0:
  - src_out=24'h200000 after edge 0.
  - dst_in=24'h100000 with src_out still set after edge 1.
  - done=1 after edge 2.
  - The encoder fed from src_out reads 5'b10110 throughout.
- Invalid codes. src=0 or src=25, dst=3:
  - No strobes, cmd_error=1, cmd_ready stays 1.
  - The next valid command (src=1, dst=2) clears cmd_error at its accept.
- Back-to-back with cmd_valid held high, SETTLE_CYCLES=3:
  - Accepts at edges 0 and 5.
  - Each transfer has src_out high for 4 cycles and exactly one dst_in pulse.
- Self-reload, src=dst=24 (C): src_out=dst_in=24'h800000 in LATCH; done pulses.
- clear=0 asserted in LATCH between edges:
  - All outputs drop immediately with no done.
  - After release, cmd_ready=1 and a fresh transfer completes normally.
- With BUS_XFER_COUNT_EN defined:
  - 3 valid transfers plus 1 invalid give xfer_count=3.
  - Preloading via 65535 transfers shows saturation at 16'hFFFF.

Source files
------------

// File: rtl/bus_xfer_pkg.sv
// Shared types and bus code constants for the bus transfer sequencer.
// Datapath bus codes: 1..16 = R0..R15, then HI, LO, ZHI, ZLO, PC, MDR, Inport, C.
package bus_xfer_pkg;

  localparam int DEF_NUM_SRC = 24;
  localparam int DEF_CODE_W  = 5;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2
  } xfer_state_t;

  localparam logic [4:0] CODE_NONE   = 5'd0;
  localparam logic [4:0] CODE_R0     = 5'd1;
  localparam logic [4:0] CODE_R1     = 5'd2;
  localparam logic [4:0] CODE_R2     = 5'd3;
  localparam logic [4:0] CODE_R3     = 5'd4;
  localparam logic [4:0] CODE_R4     = 5'd5;
  localparam logic [4:0] CODE_R5     = 5'd6;
  localparam logic [4:0] CODE_R6     = 5'd7;
  localparam logic [4:0] CODE_R7     = 5'd8;
  localparam logic [4:0] CODE_R8     = 5'd9;
  localparam logic [4:0] CODE_R9     = 5'd10;
  localparam logic [4:0] CODE_R10    = 5'd11;
  localparam logic [4:0] CODE_R11    = 5'd12;
  localparam logic [4:0] CODE_R12    = 5'd13;
  localparam logic [4:0] CODE_R13    = 5'd14;
  localparam logic [4:0] CODE_R14    = 5'd15;
  localparam logic [4:0] CODE_R15    = 5'd16;
  localparam logic [4:0] CODE_HI     = 5'd17;
  localparam logic [4:0] CODE_LO     = 5'd18;
  localparam logic [4:0] CODE_ZHI    = 5'd19;
  localparam logic [4:0] CODE_ZLO    = 5'd20;
  localparam logic [4:0] CODE_PC     = 5'd21;
  localparam logic [4:0] CODE_MDR    = 5'd22;
  localparam logic [4:0] CODE_INPORT = 5'd23;
  localparam logic [4:0] CODE_C      = 5'd24;

endpackage

// File: rtl/bus_code_decoder.sv
// Bus code to one-hot strobe decoder; code c drives bit c-1.
// Code 0 and codes above NUM_SRC decode to all-zero with valid_o low.
module bus_code_decoder
  import bus_xfer_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int CODE_W  = DEF_CODE_W
) (
  input  logic [CODE_W-1:0]  code_i,
  output logic [NUM_SRC-1:0] onehot_o,
  output logic               valid_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      onehot_o[i] = (int'(code_i) == i + 1);
    end
    valid_o = |onehot_o;
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Register-transfer sequencer: drive one source strobe, settle, load one dest.
// Optional BUS_XFER_COUNT_EN adds a saturating completed-transfer counter.
module bus_transfer_sequencer
  import bus_xfer_pkg::*;
#(
  parameter int NUM_SRC       = DEF_NUM_SRC,
  parameter int CODE_W        = DEF_CODE_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CODE_W-1:0]  cmd_src,
  input  logic [CODE_W-1:0]  cmd_dst,
  output logic [NUM_SRC-1:0] src_out,
  output logic [NUM_SRC-1:0] dst_in,
  output logic               busy,
  output logic               done,
  output logic               cmd_error
`ifdef BUS_XFER_COUNT_EN
  ,
  output logic [15:0]        xfer_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  xfer_state_t        state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] dst_sel_q;
  logic [NUM_SRC-1:0] dst_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [NUM_SRC-1:0] src_oh;
  logic [NUM_SRC-1:0] dst_oh;
  logic               src_ok;
  logic               dst_ok;

  bus_code_decoder #(
    .NUM_SRC (NUM_SRC),
    .CODE_W  (CODE_W)
  ) u_src_dec (
    .code_i   (cmd_src),
    .onehot_o (src_oh),
    .valid_o  (src_ok)
  );

  bus_code_decoder #(
    .NUM_SRC (NUM_SRC),
    .CODE_W  (CODE_W)
  ) u_dst_dec (
    .code_i   (cmd_dst),
    .onehot_o (dst_oh),
    .valid_o  (dst_ok)
  );

  // Gated by clear so ready is low for the whole reset interval.
  assign cmd_ready = (state_q == IDLE) && clear;

`ifdef BUS_XFER_COUNT_EN
  logic [15:0] cnt_xfer_q;
  assign xfer_count = cnt_xfer_q;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      src_q     <= '0;
      dst_sel_q <= '0;
      dst_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef BUS_XFER_COUNT_EN
      cnt_xfer_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (src_ok && dst_ok) begin
              state_q   <= DRIVE;
              src_q     <= src_oh;
              dst_sel_q <= dst_oh;
              cnt_q     <= CNT_INIT;
              busy_q    <= 1'b1;
              err_q     <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            state_q <= LATCH;
            dst_q   <= dst_sel_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LATCH: begin
          state_q <= IDLE;
          src_q   <= '0;
          dst_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
`ifdef BUS_XFER_COUNT_EN
          if (cnt_xfer_q != 16'hFFFF) begin
            cnt_xfer_q <= cnt_xfer_q + 16'd1;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign src_out   = src_q;
  assign dst_in    = dst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_error = err_q;

endmodule
